// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - display load/scan signal bundle for seven_seg_scan_ctrl
//
// Groups the load handshake (load, value_in, digit_en_in, dp_en_in) and the
// display pin / status outputs (AN, SEG, DP, pending, frame_done).
//   master : producer of display contents, observer of pins and status
//   slave  : the scan controller
interface seven_seg_scan_ctrl_if;
    logic        load;
    logic [31:0] value_in;
    logic [7:0]  digit_en_in;
    logic [7:0]  dp_en_in;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        pending;
    logic        frame_done;

    modport master (
        output load, value_in, digit_en_in, dp_en_in,
        input  AN, SEG, DP, pending, frame_done
    );

    modport slave (
        input  load, value_in, digit_en_in, dp_en_in,
        output AN, SEG, DP, pending, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - eight-digit common-anode 7-segment scan controller
//
// Cycles one shared hex decoder across eight digits. Each slot is BLANK_CYCLES
// of all-off followed by ON_CYCLES driving one digit. New contents are captured
// into a shadow register on load and copied to the active register only at the
// frame boundary (end of digit 7 drive), so a frame is never torn.
//
// Ports:
//   CLK100MHZ  : clock, rising edge
//   CPU_RESETN : asynchronous active-low reset
//   disp       : slave modport of seven_seg_scan_ctrl_if
//                load/value_in/digit_en_in/dp_en_in in,
//                AN/SEG/DP (active low), pending, frame_done out
module seven_seg_scan_ctrl #(
    parameter int ON_CYCLES    = 12500,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  CLK100MHZ,
    input  logic                  CPU_RESETN,
    seven_seg_scan_ctrl_if.slave  disp
);

    localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    // A single-cycle phase still needs one counter bit to exist.
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

    phase_t        r_phase;
    phase_t        w_phase_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_digit;
    logic [2:0]    w_digit_nxt;
    logic          w_boundary;

    logic [31:0]   r_sh_val;
    logic [7:0]    r_sh_en;
    logic [7:0]    r_sh_dp;
    logic [31:0]   r_act_val;
    logic [7:0]    r_act_en;
    logic [7:0]    r_act_dp;
    logic          r_pending;
    logic          r_frame_done;

    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [7:0]    w_an_nxt;
    logic [6:0]    w_seg_nxt;
    logic          w_dp_nxt;
    logic [3:0]    w_nib;
    logic [6:0]    w_lit;

    // Phase/slot sequencer
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_phase <= BLANK;
            r_cnt   <= '0;
            r_digit <= 3'd0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            r_digit <= w_digit_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_digit_nxt = r_digit;
        w_boundary  = 1'b0;
        case (r_phase)
            BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_phase_nxt = DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            DRIVE: begin
                if (r_cnt == ON_LAST) begin
                    w_phase_nxt = BLANK;
                    w_cnt_nxt   = '0;
                    w_digit_nxt = r_digit + 3'd1;
                    w_boundary  = (r_digit == 3'd7);
                end
            end
            default: begin
                w_phase_nxt = BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Shared hex decoder; bit 0 = segment a ... bit 6 = segment g, 1 = lit
    assign w_nib = r_act_val[{r_digit, 2'b00} +: 4];

    always_comb begin
        w_lit = 7'h00;
        case (w_nib)
            4'h0: w_lit = 7'h3F;
            4'h1: w_lit = 7'h06;
            4'h2: w_lit = 7'h5B;
            4'h3: w_lit = 7'h4F;
            4'h4: w_lit = 7'h66;
            4'h5: w_lit = 7'h6D;
            4'h6: w_lit = 7'h7D;
            4'h7: w_lit = 7'h07;
            4'h8: w_lit = 7'h7F;
            4'h9: w_lit = 7'h6F;
            4'hA: w_lit = 7'h77;
            4'hB: w_lit = 7'h7C;
            4'hC: w_lit = 7'h39;
            4'hD: w_lit = 7'h5E;
            4'hE: w_lit = 7'h79;
            4'hF: w_lit = 7'h71;
            default: w_lit = 7'h00;
        endcase
    end

    // Pin values for the current state; registered below so the pins show the
    // slot one cycle later and never glitch between digits.
    always_comb begin
        w_an_nxt  = 8'hFF;
        w_seg_nxt = 7'h7F;
        w_dp_nxt  = 1'b1;
        if (r_phase == DRIVE) begin
            w_seg_nxt = ~w_lit;
            if (r_act_en[r_digit]) begin
                w_an_nxt = ~(8'b1 << r_digit);
                w_dp_nxt = ~r_act_dp[r_digit];
            end
        end
    end

    // Double-buffered contents. A load on the boundary edge still lands in the
    // shadow and keeps pending set; the boundary applies the pre-edge shadow.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_sh_val     <= '0;
            r_sh_en      <= '0;
            r_sh_dp      <= '0;
            r_act_val    <= '0;
            r_act_en     <= '0;
            r_act_dp     <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_an         <= 8'hFF;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
        end else begin
            r_frame_done <= w_boundary;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_dp         <= w_dp_nxt;
            if (w_boundary && r_pending) begin
                r_act_val <= r_sh_val;
                r_act_en  <= r_sh_en;
                r_act_dp  <= r_sh_dp;
            end
            if (disp.load) begin
                r_sh_val  <= disp.value_in;
                r_sh_en   <= disp.digit_en_in;
                r_sh_dp   <= disp.dp_en_in;
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign disp.AN         = r_an;
    assign disp.SEG        = r_seg;
    assign disp.DP         = r_dp;
    assign disp.pending    = r_pending;
    assign disp.frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

    localparam int ON = 4;
    localparam int BL = 2;
    localparam int S  = ON + BL;
    localparam int F  = 8 * S;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_ctrl_if u_if();

    seven_seg_scan_ctrl #(
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL)
    ) u_dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .disp       (u_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] lit7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  en;
        logic [7:0]  dp;
    } frame_t;

    // Scoreboard: loads are queued when driven, popped at the boundary that
    // should apply them.
    frame_t     sb_q[$];
    frame_t     m_act;
    bit         m_pend;
    int         e;
    logic [7:0] x_an;
    logic [6:0] x_seg;
    logic       x_dp;
    logic       x_pend;
    logic       x_fd;

    initial begin
        int     p;
        int     d;
        frame_t nf;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e = 0; m_act = '0; m_pend = 0; sb_q.delete();
                x_an = 8'hFF; x_seg = 7'h7F; x_dp = 1'b1; x_pend = 1'b0; x_fd = 1'b0;
            end else begin
                e++;
                p = e - 1;
                d = (p / S) % 8;
                x_an = 8'hFF; x_seg = 7'h7F; x_dp = 1'b1;
                if ((p % S) >= BL) begin
                    x_seg = ~lit7(m_act.val[4*d +: 4]);
                    if (m_act.en[d]) begin
                        x_an = ~(8'b1 << d);
                        x_dp = ~m_act.dp[d];
                    end
                end
                x_fd = ((e % F) == 0);
                if (x_fd && m_pend) begin
                    m_act  = sb_q.pop_front();
                    m_pend = 0;
                end
                if (u_if.load) begin
                    if (sb_q.size() > 0) void'(sb_q.pop_back());
                    nf = {u_if.value_in, u_if.digit_en_in, u_if.dp_en_in};
                    sb_q.push_back(nf);
                    m_pend = 1;
                end
                x_pend = m_pend;
            end
            @(negedge clk);
            if (!rst_n) begin
                x_an = 8'hFF; x_seg = 7'h7F; x_dp = 1'b1; x_pend = 1'b0; x_fd = 1'b0;
            end
            chk($sformatf("mon_AN e=%0d", e), u_if.AN, x_an);
            chk($sformatf("mon_SEG e=%0d", e), u_if.SEG, x_seg);
            chk($sformatf("mon_DP e=%0d", e), u_if.DP, x_dp);
            chk($sformatf("mon_pending e=%0d", e), u_if.pending, x_pend);
            chk($sformatf("mon_frame_done e=%0d", e), u_if.frame_done, x_fd);
        end
    end

    // Called just after a negedge; load is seen by the following posedge.
    task automatic do_load(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dp);
        u_if.load        = 1'b1;
        u_if.value_in    = v;
        u_if.digit_en_in = en;
        u_if.dp_en_in    = dp;
        @(negedge clk);
        u_if.load = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 2 * F && !got; i++) begin
            @(negedge clk);
            got = u_if.frame_done;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s frame_done timeout actual=0 expected=1", name);
        end
    endtask

    typedef struct {
        logic [31:0] val;
        logic [7:0]  en;
        logic [7:0]  dp;
        int          dig;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    vec_t vt [6];

    initial begin
        int ones;
        int twos;
        int lit_cnt;

        vt[0] = '{32'h7654_3210, 8'hFF, 8'h01, 0, 8'hFE, 7'h40, 1'b0};
        vt[1] = '{32'h7654_3210, 8'hFF, 8'h01, 1, 8'hFD, 7'h79, 1'b1};
        vt[2] = '{32'hFFFF_FFFF, 8'h80, 8'h00, 7, 8'h7F, 7'h0E, 1'b1};
        vt[3] = '{32'hFFFF_FFFF, 8'h80, 8'h00, 0, 8'hFF, 7'h0E, 1'b1};
        vt[4] = '{32'h0000_A000, 8'h08, 8'h08, 3, 8'hF7, 7'h08, 1'b0};
        vt[5] = '{32'h0D00_0000, 8'h40, 8'h00, 6, 8'hBF, 7'h21, 1'b1};

        u_if.load        = 1'b0;
        u_if.value_in    = '0;
        u_if.digit_en_in = '0;
        u_if.dp_en_in    = '0;

        // Reset hold
        repeat (5) @(negedge clk);
        chk("rst_AN", u_if.AN, 8'hFF);
        chk("rst_SEG", u_if.SEG, 7'h7F);
        chk("rst_DP", u_if.DP, 1'b1);
        chk("rst_pending", u_if.pending, 1'b0);
        rst_n = 1'b1;

        // First frame must stay dark
        lit_cnt = 0;
        repeat (F) begin
            @(negedge clk);
            if (u_if.AN != 8'hFF) lit_cnt++;
        end
        chk("first_frame_dark", lit_cnt, 0);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            do_load(vt[i].val, vt[i].en, vt[i].dp);
            chk($sformatf("vec%0d_pending_set", i), u_if.pending, 1'b1);
            wait_fd($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_pending_clr", i), u_if.pending, 1'b0);
            repeat (S * vt[i].dig + BL + 1) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_AN", i), u_if.AN, vt[i].an);
            chk($sformatf("vec%0d_SEG", i), u_if.SEG, vt[i].seg);
            chk($sformatf("vec%0d_DP", i), u_if.DP, vt[i].dpo);
        end

        // Tear-free update: two loads mid-frame, only the last one shows next frame
        wait_fd("tear_sync");
        repeat (20) @(negedge clk);
        do_load(32'h1111_1111, 8'hFF, 8'h00);
        repeat (2) @(negedge clk);
        do_load(32'h2222_2222, 8'hFF, 8'h00);
        wait_fd("tear_apply");
        ones = 0;
        twos = 0;
        repeat (F) begin
            @(negedge clk);
            if (u_if.SEG == 7'h79) ones++;
            if (u_if.SEG == 7'h24 && u_if.AN != 8'hFF) twos++;
        end
        chk("tear_one_never", ones, 0);
        chk("tear_two_cycles", twos, 8 * ON);
        chk("tear_frame_done", u_if.frame_done, 1'b1);

        // Boundary collision: A mid-frame, B on the boundary edge
        repeat (9) @(negedge clk);
        do_load(32'h3333_3333, 8'hFF, 8'h00);
        repeat (37) @(negedge clk);
        do_load(32'h5555_5555, 8'hFF, 8'hFF);
        chk("coll_frame_done", u_if.frame_done, 1'b1);
        chk("coll_pending_kept", u_if.pending, 1'b1);
        repeat (BL + 1) @(posedge clk);
        @(negedge clk);
        chk("coll_A_SEG", u_if.SEG, 7'h30);
        chk("coll_A_DP", u_if.DP, 1'b1);
        wait_fd("coll_B");
        chk("coll_pending_clr", u_if.pending, 1'b0);
        repeat (BL + 1) @(posedge clk);
        @(negedge clk);
        chk("coll_B_AN", u_if.AN, 8'hFE);
        chk("coll_B_SEG", u_if.SEG, 7'h12);
        chk("coll_B_DP", u_if.DP, 1'b0);

        // Mid-frame reset during digit 3 drive, with a load still pending
        do_load(32'h7777_7777, 8'hFF, 8'h00);
        repeat (S * 3 - 1) @(posedge clk);
        #2;
        chk("mrst_AN_before", u_if.AN, 8'hF7);
        chk("mrst_pending_before", u_if.pending, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_AN_async", u_if.AN, 8'hFF);
        chk("mrst_SEG_async", u_if.SEG, 7'h7F);
        chk("mrst_pending_async", u_if.pending, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lit_cnt = 0;
        repeat (2 * F) begin
            @(negedge clk);
            if (u_if.AN != 8'hFF) lit_cnt++;
        end
        chk("mrst_dark_after", lit_cnt, 0);
        chk("mrst_pending_after", u_if.pending, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
